// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, optional single-cycle multiplier, one-cycle done window.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] oper1_i,
  input  logic [XLEN-1:0] oper2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cneg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] f_mul_sel(input logic [2:0] op, input logic [2*XLEN-1:0] p);
    return (op == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_hi, r_lo;
  logic              r_neg_q, r_neg_r;

  logic              w_is_div, w_sgn1, w_sgn2, w_s1, w_s2;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic              w_div0, w_ovf, w_fast, w_accept, w_short;
  logic [2*XLEN-1:0] w_fast_prod;
  logic [XLEN-1:0]   w_short_res;
  logic [XLEN:0]     w_sum, w_rs, w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_calc_res;
  logic              w_last;

  // Accept-side decode: signedness, magnitudes and short-path detection
  assign w_is_div = op_i[2];
  assign w_sgn1   = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
  assign w_sgn2   = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
  assign w_s1     = w_sgn1 & oper1_i[XLEN-1];
  assign w_s2     = w_sgn2 & oper2_i[XLEN-1];
  assign w_mag1   = f_cneg(oper1_i, w_s1);
  assign w_mag2   = f_cneg(oper2_i, w_s2);

  assign w_div0   = w_is_div & (oper2_i == '0);
  assign w_ovf    = w_is_div & ~op_i[0] & (oper1_i == MIN_NEG) & (&oper2_i);
  assign w_fast   = FAST_MUL & ~w_is_div;
  assign w_accept = (r_state == S_IDLE) & valid_i & ~flush_i;
  assign w_short  = w_div0 | w_ovf | w_fast;

  generate
    if (FAST_MUL) begin : g_fast_mul
      assign w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    end else begin : g_no_fast_mul
      assign w_fast_prod = '0;
    end
  endgenerate

  always_comb begin
    w_short_res = '0;
    if (w_div0)     w_short_res = op_i[1] ? oper1_i : '1;
    else if (w_ovf) w_short_res = op_i[1] ? '0 : oper1_i;
    else            w_short_res = f_mul_sel(op_i, f_cneg2(w_fast_prod, w_s1 ^ w_s2));
  end

  // Iteration step: multiply adds into the high half and shifts right; divide
  // shifts the remainder left and keeps the trial difference when non-negative.
  assign w_sum  = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_a}) : {1'b0, r_hi};
  assign w_rs   = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_rs - {1'b0, r_a};
  assign w_ge   = ~w_diff[XLEN];

  assign w_hi_nxt = r_op[2] ? (w_ge ? w_diff[XLEN-1:0] : w_rs[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_lo_nxt = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};

  always_comb begin
    w_calc_res = '0;
    if (r_op[2]) w_calc_res = r_op[1] ? f_cneg(w_hi_nxt, r_neg_r) : f_cneg(w_lo_nxt, r_neg_q);
    else         w_calc_res = f_mul_sel(r_op, f_cneg2({w_hi_nxt, w_lo_nxt}, r_neg_q));
  end

  assign w_last = (r_state == S_CALC) && (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_short ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_cnt <= CNT_INIT;
        if (w_short) r_result <= w_short_res;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last && !flush_i) r_result <= w_calc_res;
      end
    end
  end

  // Working registers carry only data and need no reset
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_op    <= op_i;
      r_a     <= w_is_div ? w_mag2 : w_mag1;
      r_lo    <= w_is_div ? w_mag1 : w_mag2;
      r_hi    <= '0;
      r_neg_q <= w_s1 ^ w_s2;
      r_neg_r <= w_s1;
    end else if (r_state == S_CALC) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign stall_o  = valid_i & ~flush_i & (r_state != S_DONE);
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit that sits beside the ALU in the EX stage. It accepts one M-extension operation at a time from ID/EX, stalls the pipeline while it computes, and returns the `rd` value in a one-cycle done window. Its output is muxed into the EX/MEM `rd` data path. Width and multiplier style are parametrised, so the same block serves RV32 and RV64 cores.

## Interface

Parameters:
- `XLEN`, default 32: operand/result width; legal values are 32 and 64.
- `FAST_MUL`, default 0: 1 selects a single-cycle multiplier; 0 selects shift-add (radix-2).

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset. Asynchronous, active-low.
- `valid_i`  in  1  the EX instruction is an M-op. Held high while stalled.
- `op_i`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `oper1_i`  in  XLEN  forwarded rs1 value.
- `oper2_i`  in  XLEN  forwarded rs2 value.
- `flush_i`  in  1  kills any in-flight op.
- `stall_o`  out  1  combinational; holds IF/ID/EX.
- `busy_o`  out  1  registered state is not IDLE.
- `done_o`  out  1  registered; `result_o` is valid this cycle.
- `result_o`  out  XLEN  registered result.

## Operation

- FSM states are IDLE, CALC, DONE.
- IDLE → CALC: `valid_i & !flush_i` with a normal op. The unit latches operands, op and sign info, and loads the counter with XLEN-1.
- IDLE → DONE directly when any of the following holds:
  - divisor == 0;
  - signed overflow (DIV/REM with dividend = 100…0 and divisor = all-ones);
  - a multiply op with `FAST_MUL=1`.
- CALC → DONE when the counter reaches 0. The counter decrements once per cycle.
- DONE → IDLE unconditionally. `valid_i` is ignored in DONE, so the finished instruction is never re-accepted.
- `flush_i` in any state forces the next state to IDLE. `done_o` is then 0 next cycle. A request in the same cycle as `flush_i` is not accepted.
- `stall_o = valid_i & !flush_i & (state != DONE)`.
- Operands are latched at accept. Later changes on `oper*_i` (forwarding sources draining) have no effect.

Arithmetic rules:
- Signed operands are converted to magnitudes at accept:
  - MULH: both operands signed.
  - MULHSU: `oper1_i` signed, `oper2_i` unsigned.
  - DIV/REM: both operands signed.
- Multiply accumulates a 2·XLEN-bit unsigned product. The final sign is the XOR of the operand signs; a negative result is the two's complement of the full 2·XLEN product.
  - MUL returns bits [XLEN-1:0].
  - MULH, MULHSU and MULHU return bits [2·XLEN-1:XLEN].
- Divide is restoring, one quotient bit per cycle.
  - Quotient sign = XOR of the signs.
  - Remainder sign = sign of the dividend.
- Special-case results:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Overflow: DIV returns the dividend; REM returns 0.

Reset and boundary behaviour:
- Reset values: state IDLE, `result_o`=0, `done_o`=0, `busy_o`=0, counter=0.
- `stall_o`=0 while `valid_i`=0.
- Reset asserted mid-CALC immediately returns the unit to IDLE with no `done_o` pulse.

## Timing

- Accept cycle is c0 (IDLE, `valid_i`=1, `stall_o`=1).
- Iterative op:
  - CALC occupies c1…cXLEN.
  - DONE in cXLEN+1: `done_o`=1, `stall_o`=0, the EX/MEM register captures `result_o`.
  - EX occupancy is XLEN+2 cycles (34 for XLEN=32).
- Special-case or fast-multiply op: DONE in c1; occupancy is 2 cycles.
- `done_o` is exactly one cycle wide. The next op can be accepted in cXLEN+2 (or c2 for the short path).
- Back-to-back ops: a new `valid_i` in the cycle after DONE is accepted normally.
- No combinational path from `oper*_i` to `result_o`. `stall_o` depends only on `valid_i`, `flush_i` and state.

## Test plan

- **MUL**, XLEN=32, `FAST_MUL`=0, 7 × 0xFFFFFFFD → `result_o`=0xFFFFFFEB with `done_o` in c33. `stall_o` is high for c0–c32 and low in c33.
- **MULH and MULHU:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - Repeat MULHU with `FAST_MUL`=1: same result, `done_o` in c1.
- **Divide corner cases**, each with `done_o` in c1:
  - DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- **Signed division:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
  - Each completes in c33.
- **Flush:** DIV accepted, `flush_i` pulsed in c10 → no `done_o`, `busy_o`=0 in c11. A MUL presented in c11 is accepted and correct. Separately, `valid_i` and `flush_i` together in IDLE → not accepted.
- **Mid-CALC disturbances:**
  - `rstn_i` asserted asynchronously mid-CALC → all outputs immediately at reset values.
  - Changing `oper*_i` during CALC → result unchanged.
